// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP CPU port controller and its register file.
package vdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } port_state_t;

    typedef enum logic [1:0] {
        MODE_TEXT = 2'd0,
        MODE_G1   = 2'd1,
        MODE_G2   = 2'd2,
        MODE_MC   = 2'd3
    } vdp_mode_t;

    localparam int NUM_REGS = 8;

    localparam logic [2:0] REG_MODE0  = 3'd0;
    localparam logic [2:0] REG_MODE1  = 3'd1;
    localparam logic [2:0] REG_NAME   = 3'd2;
    localparam logic [2:0] REG_COLOR  = 3'd3;
    localparam logic [2:0] REG_FONT   = 3'd4;
    localparam logic [2:0] REG_SATTR  = 3'd5;
    localparam logic [2:0] REG_SPAT   = 3'd6;
    localparam logic [2:0] REG_COLORS = 3'd7;

    localparam logic [7:0] REG1_RST    = 8'h40;
    localparam logic [7:0] REG7_RST    = 8'hF4;
    localparam logic [7:0] REG_DEF_RST = 8'h00;

    function automatic logic [7:0] reg_reset_value(input logic [2:0] idx);
        case (idx)
            REG_MODE1:  return REG1_RST;
            REG_COLORS: return REG7_RST;
            default:    return REG_DEF_RST;
        endcase
    endfunction

    // Text overrides multicolor, which overrides graphics II; graphics I otherwise.
    function automatic vdp_mode_t decode_mode(input logic [7:0] r0, input logic [7:0] r1);
        if (r1[4])      return MODE_TEXT;
        else if (r1[3]) return MODE_MC;
        else if (r0[1]) return MODE_G2;
        else            return MODE_G1;
    endfunction

endpackage

// File: rtl/vdp_port_ctrl_if.sv
// CPU strobe/data bus and CPU-side VRAM port of the VDP.
interface vdp_port_ctrl_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_mode;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [13:0] vram_addr;
    logic        vram_wr;
    logic        vram_rd;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;

    modport master (
        output cpu_rd, cpu_wr, cpu_mode, cpu_din, vram_dout,
        input  cpu_dout, cpu_wait, vram_addr, vram_wr, vram_rd, vram_din
    );

    modport slave (
        input  cpu_rd, cpu_wr, cpu_mode, cpu_din, vram_dout,
        output cpu_dout, cpu_wait, vram_addr, vram_wr, vram_rd, vram_din
    );
endinterface

// File: rtl/vdp_regfile.sv
// Eight VDP control registers with mode and table base address decode.
module vdp_regfile
    import vdp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  widx,
    input  logic [7:0]  wdata,
    output logic [1:0]  mode,
    output logic        ie,
    output logic        video_on,
    output logic [3:0]  text_color,
    output logic [3:0]  back_color,
    output logic        sprite_large,
    output logic        sprite_enlarged,
    output logic [13:0] name_table_addr,
    output logic [13:0] color_table_addr,
    output logic [13:0] font_addr,
    output logic [13:0] sprite_attr_addr,
    output logic [13:0] sprite_pattern_table_addr
);

    logic [7:0] regs [NUM_REGS];
    vdp_mode_t  mode_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= reg_reset_value(3'(i));
            end
        end else if (we) begin
            regs[widx] <= wdata;
        end
    end

    // Graphics II splits colour and pattern tables into 8K halves.
    always_comb begin
        mode_dec                  = decode_mode(regs[REG_MODE0], regs[REG_MODE1]);
        mode                      = mode_dec;
        ie                        = regs[REG_MODE1][5];
        video_on                  = regs[REG_MODE1][6];
        sprite_large              = regs[REG_MODE1][1];
        sprite_enlarged           = regs[REG_MODE1][0];
        text_color                = regs[REG_COLORS][7:4];
        back_color                = regs[REG_COLORS][3:0];
        name_table_addr           = {regs[REG_NAME][3:0], 10'b0};
        sprite_attr_addr          = {regs[REG_SATTR][6:0], 7'b0};
        sprite_pattern_table_addr = {regs[REG_SPAT][2:0], 11'b0};
        if (mode_dec == MODE_G2) begin
            color_table_addr = {regs[REG_COLOR][7], 13'b0};
            font_addr        = {regs[REG_FONT][2], 13'b0};
        end else begin
            color_table_addr = {regs[REG_COLOR], 6'b0};
            font_addr        = {regs[REG_FONT][2:0], 11'b0};
        end
    end

endmodule

// File: rtl/vdp_port_ctrl.sv
// VDP CPU port: two-byte control protocol, auto-incrementing VRAM access and status flags.
module vdp_port_ctrl
    import vdp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    vdp_port_ctrl_if.slave        bus,
    input  logic                  frame_pulse,
    input  logic                  sprite_collision,
    input  logic                  too_many_sprites,
    input  logic [4:0]            sprite5,
    output logic                  n_int,
    output logic [1:0]            mode,
    output logic                  video_on,
    output logic [3:0]            text_color,
    output logic [3:0]            back_color,
    output logic                  sprite_large,
    output logic                  sprite_enlarged,
    output logic [13:0]           name_table_addr,
    output logic [13:0]           color_table_addr,
    output logic [13:0]           font_addr,
    output logic [13:0]           sprite_attr_addr,
    output logic [13:0]           sprite_pattern_table_addr
);

    port_state_t state, state_nxt;
    logic        first_flag;
    logic [7:0]  latch_byte;
    logic [13:0] addr;
    logic [7:0]  rd_buf;
    logic        flag_f, flag_5s, flag_c;
    logic [4:0]  spr5_lat;
    logic        ie;

    logic acc_wr, acc_rd, data_wr, data_rd, ctl_wr, stat_rd;
    logic second_byte, reg_we, addr_load, prefetch;

    // Strobes are only accepted in IDLE; a write wins over a simultaneous read.
    always_comb begin
        acc_wr      = (state == ST_IDLE) && bus.cpu_wr;
        acc_rd      = (state == ST_IDLE) && bus.cpu_rd && !bus.cpu_wr;
        data_wr     = acc_wr && !bus.cpu_mode;
        data_rd     = acc_rd && !bus.cpu_mode;
        ctl_wr      = acc_wr && bus.cpu_mode;
        stat_rd     = acc_rd && bus.cpu_mode;
        second_byte = ctl_wr && first_flag;
        reg_we      = second_byte && bus.cpu_din[7];
        addr_load   = second_byte && !bus.cpu_din[7];
        prefetch    = addr_load && !bus.cpu_din[6];

        state_nxt    = state;
        bus.vram_wr  = 1'b0;
        bus.vram_rd  = 1'b0;
        bus.cpu_wait = 1'b0;
        case (state)
            ST_IDLE: begin
                if (data_wr)                 state_nxt = ST_WR;
                else if (data_rd || prefetch) state_nxt = ST_RD_REQ;
            end
            ST_WR: begin
                bus.vram_wr  = 1'b1;
                bus.cpu_wait = 1'b1;
                state_nxt    = ST_IDLE;
            end
            ST_RD_REQ: begin
                bus.vram_rd  = 1'b1;
                bus.cpu_wait = 1'b1;
                state_nxt    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                bus.cpu_wait = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (ctl_wr && !first_flag) latch_byte <= bus.cpu_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_flag   <= 1'b0;
            addr         <= '0;
            rd_buf       <= '0;
            bus.cpu_dout <= '0;
        end else begin
            if (ctl_wr)                            first_flag <= !first_flag;
            else if (data_wr || data_rd || stat_rd) first_flag <= 1'b0;

            // Post-increment after the VRAM pulse; the 14-bit counter wraps naturally.
            if (addr_load)                                    addr <= {bus.cpu_din[5:0], latch_byte};
            else if (state == ST_WR || state == ST_RD_REQ)    addr <= addr + 14'd1;

            if (data_wr)                  rd_buf <= bus.cpu_din;
            else if (state == ST_RD_WAIT) rd_buf <= bus.vram_dout;

            if (data_rd)      bus.cpu_dout <= rd_buf;
            else if (stat_rd) bus.cpu_dout <= {flag_f, flag_5s, flag_c, spr5_lat};
        end
    end

    // A set in the same cycle as a status read takes priority over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_f   <= 1'b0;
            flag_5s  <= 1'b0;
            flag_c   <= 1'b0;
            spr5_lat <= '0;
        end else begin
            flag_f  <= frame_pulse || (flag_f && !stat_rd);
            flag_c  <= sprite_collision || (flag_c && !stat_rd);
            flag_5s <= too_many_sprites || (flag_5s && !stat_rd);
            if (too_many_sprites) spr5_lat <= sprite5;
        end
    end

    assign bus.vram_addr = addr;
    assign bus.vram_din  = rd_buf;
    assign n_int         = !(flag_f && ie);

    vdp_regfile u_regfile (
        .clk                       (clk),
        .reset                     (reset),
        .we                        (reg_we),
        .widx                      (bus.cpu_din[2:0]),
        .wdata                     (latch_byte),
        .mode                      (mode),
        .ie                        (ie),
        .video_on                  (video_on),
        .text_color                (text_color),
        .back_color                (back_color),
        .sprite_large              (sprite_large),
        .sprite_enlarged           (sprite_enlarged),
        .name_table_addr           (name_table_addr),
        .color_table_addr          (color_table_addr),
        .font_addr                 (font_addr),
        .sprite_attr_addr          (sprite_attr_addr),
        .sprite_pattern_table_addr (sprite_pattern_table_addr)
    );

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Scoreboard bench for vdp_port_ctrl: behavioural model feeds expected VRAM/CPU events to a monitor.
`timescale 1ns/1ps
module tb_vdp_port_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vdp_port_ctrl_if bus ();

    logic        frame_pulse, sprite_collision, too_many_sprites;
    logic [4:0]  sprite5;
    logic        n_int, video_on, sprite_large, sprite_enlarged;
    logic [1:0]  mode;
    logic [3:0]  text_color, back_color;
    logic [13:0] name_table_addr, color_table_addr, font_addr;
    logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;

    vdp_port_ctrl dut (
        .clk                       (clk),
        .reset                     (reset),
        .bus                       (bus.slave),
        .frame_pulse               (frame_pulse),
        .sprite_collision          (sprite_collision),
        .too_many_sprites          (too_many_sprites),
        .sprite5                   (sprite5),
        .n_int                     (n_int),
        .mode                      (mode),
        .video_on                  (video_on),
        .text_color                (text_color),
        .back_color                (back_color),
        .sprite_large              (sprite_large),
        .sprite_enlarged           (sprite_enlarged),
        .name_table_addr           (name_table_addr),
        .color_table_addr          (color_table_addr),
        .font_addr                 (font_addr),
        .sprite_attr_addr          (sprite_attr_addr),
        .sprite_pattern_table_addr (sprite_pattern_table_addr)
    );

    // VRAM responder: read data appears the cycle after vram_rd.
    logic [7:0] vram [16384];
    always @(posedge clk) begin
        if (bus.vram_wr) vram[bus.vram_addr] <= bus.vram_din;
        if (bus.vram_rd) bus.vram_dout <= vram[bus.vram_addr];
    end

    // Reference model state
    logic [7:0]  mdl_mem [16384];
    logic [7:0]  m_regs [8];
    logic [13:0] m_addr;
    logic [7:0]  m_latch, m_buf;
    logic        m_flag, m_f, m_s5, m_c;
    logic [4:0]  m_spr5;

    typedef struct {
        bit          is_wr;
        logic [13:0] a;
        logic [7:0]  d;
    } vev_t;
    vev_t       vram_q [$];
    logic [7:0] cpu_q [$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic rd_pend = 1'b0;
        vev_t e;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (cpu_q.size() == 0) check("cpu_dout_unexpected", 32'(bus.cpu_dout), 32'hFFFF_FFFF);
                else                   check("cpu_dout", 32'(bus.cpu_dout), 32'(cpu_q.pop_front()));
            end
            if (bus.vram_wr === 1'b1 || bus.vram_rd === 1'b1) begin
                if (vram_q.size() == 0) begin
                    check("vram_unexpected", {bus.vram_wr, bus.vram_rd}, 0);
                end else begin
                    e = vram_q.pop_front();
                    check("vram_op", {bus.vram_wr, bus.vram_rd}, e.is_wr ? 2'b10 : 2'b01);
                    check("vram_addr", 32'(bus.vram_addr), 32'(e.a));
                    if (e.is_wr) check("vram_din", 32'(bus.vram_din), 32'(e.d));
                end
            end
            rd_pend = bus.cpu_rd && !bus.cpu_wr && !bus.cpu_wait && !reset;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit wr, input bit rd, input bit md, input logic [7:0] d, input int hold);
        bus.cpu_wr   = wr;
        bus.cpu_rd   = rd;
        bus.cpu_mode = md;
        bus.cpu_din  = d;
        repeat (hold) tick();
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.cpu_wait && n < 8) begin
            tick();
            n++;
        end
        check("cpu_wait_release", 32'(bus.cpu_wait), 0);
    endtask

    task automatic model_reset();
        m_addr = '0; m_buf = '0; m_flag = 0;
        m_f = 0; m_s5 = 0; m_c = 0; m_spr5 = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_regs[1] = 8'h40;
        m_regs[7] = 8'hF4;
    endtask

    task automatic ctl_write(input logic [7:0] d, input bit both);
        if (!m_flag) begin
            m_latch = d;
            m_flag  = 1;
        end else begin
            m_flag = 0;
            if (d[7]) begin
                m_regs[d[2:0]] = m_latch;
            end else begin
                m_addr = {d[5:0], m_latch};
                if (!d[6]) begin
                    vram_q.push_back('{is_wr: 1'b0, a: m_addr, d: 8'h00});
                    m_buf  = mdl_mem[m_addr];
                    m_addr = m_addr + 14'd1;
                end
            end
        end
        strobe(1, both, 1, d, 1);
        wait_idle();
    endtask

    task automatic data_write(input logic [7:0] d, input bit both, input int hold);
        m_flag = 0;
        vram_q.push_back('{is_wr: 1'b1, a: m_addr, d: d});
        mdl_mem[m_addr] = d;
        m_buf  = d;
        m_addr = m_addr + 14'd1;
        strobe(1, both, 0, d, hold);
        wait_idle();
    endtask

    task automatic data_read(input int hold);
        m_flag = 0;
        cpu_q.push_back(m_buf);
        vram_q.push_back('{is_wr: 1'b0, a: m_addr, d: 8'h00});
        m_buf  = mdl_mem[m_addr];
        m_addr = m_addr + 14'd1;
        strobe(0, 1, 0, 8'($urandom), hold);
        wait_idle();
    endtask

    task automatic status_read(input bit fp);
        cpu_q.push_back({m_f, m_s5, m_c, m_spr5});
        m_f = fp; m_s5 = 0; m_c = 0; m_flag = 0;
        frame_pulse = fp;
        strobe(0, 1, 1, 8'($urandom), 1);
        frame_pulse = 1'b0;
        wait_idle();
    endtask

    task automatic video_event(input bit fp, input bit coll, input bit tms, input logic [4:0] s);
        if (fp)   m_f = 1;
        if (coll) m_c = 1;
        if (tms) begin
            m_s5   = 1;
            m_spr5 = s;
        end
        frame_pulse = fp; sprite_collision = coll; too_many_sprites = tms; sprite5 = s;
        tick();
        frame_pulse = 0; sprite_collision = 0; too_many_sprites = 0;
    endtask

    task automatic check_outputs();
        logic [1:0] em;
        em = m_regs[1][4] ? 2'd0 : m_regs[1][3] ? 2'd3 : m_regs[0][1] ? 2'd2 : 2'd1;
        check("mode", 32'(mode), 32'(em));
        check("video_on", 32'(video_on), 32'(m_regs[1][6]));
        check("sprite_large", 32'(sprite_large), 32'(m_regs[1][1]));
        check("sprite_enlarged", 32'(sprite_enlarged), 32'(m_regs[1][0]));
        check("colors", {text_color, back_color}, 32'(m_regs[7]));
        check("name_table_addr", 32'(name_table_addr), 32'({m_regs[2][3:0], 10'b0}));
        check("color_table_addr", 32'(color_table_addr),
              (em == 2'd2) ? 32'({m_regs[3][7], 13'b0}) : 32'({m_regs[3], 6'b0}));
        check("font_addr", 32'(font_addr),
              (em == 2'd2) ? 32'({m_regs[4][2], 13'b0}) : 32'({m_regs[4][2:0], 11'b0}));
        check("sprite_attr_addr", 32'(sprite_attr_addr), 32'({m_regs[5][6:0], 7'b0}));
        check("sprite_pattern_addr", 32'(sprite_pattern_table_addr), 32'({m_regs[6][2:0], 11'b0}));
        check("n_int", 32'(n_int), 32'(!(m_f && m_regs[1][5])));
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            vram[i]    = (i == 256) ? 8'h5A : 8'(i * 7 + 3);
            mdl_mem[i] = (i == 256) ? 8'h5A : 8'(i * 7 + 3);
        end
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_mode = 0; bus.cpu_din = '0;
        frame_pulse = 0; sprite_collision = 0; too_many_sprites = 0; sprite5 = '0;
        m_latch = '0;
        model_reset();
        reset = 1'b1;
        fork
            monitor();
            begin
                #2ms;
                $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
                $fatal(1);
            end
        join_none

        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_cpu_dout", 32'(bus.cpu_dout), 0);
        check("rst_strobes", {bus.vram_wr, bus.vram_rd, bus.cpu_wait}, 0);
        check("rst_n_int", 32'(n_int), 1);
        check("rst_mode", 32'(mode), 1);
        check_outputs();

        // Register write: reg2 = 0x0F
        ctl_write(8'h0F, 0);
        ctl_write(8'h82, 0);
        check("req045_name_table", 32'(name_table_addr), 32'h3C00);
        check_outputs();

        // Address wrap across 3FFF
        ctl_write(8'hFF, 0);
        ctl_write(8'h7F, 0);
        data_write(8'hAA, 0, 1);
        data_write(8'hBB, 0, 1);
        check("req046_mem_3fff", 32'(vram[14'h3FFF]), 32'hAA);
        check("req046_mem_0000", 32'(vram[14'h0000]), 32'hBB);

        // Prefetch then buffered read
        ctl_write(8'h00, 0);
        ctl_write(8'h01, 0);
        data_read(1);
        check("req047_read", 32'(bus.cpu_dout), 32'h5A);
        data_write(8'h11, 0, 1);
        check("req047_addr_0102", 32'(vram[14'h0102]), 32'h11);

        // Interrupt flag
        ctl_write(8'h60, 0);
        ctl_write(8'h81, 0);
        video_event(1, 0, 0, 5'h0);
        check("req048_n_int_low", 32'(n_int), 0);
        status_read(0);
        check("req048_status_f", 32'(bus.cpu_dout[7]), 1);
        check("req048_n_int_high", 32'(n_int), 1);
        video_event(1, 0, 0, 5'h0);
        status_read(1);
        check("req048_set_wins", 32'(n_int), 0);
        status_read(0);
        check_outputs();

        // Mode decode
        ctl_write(8'h02, 0);
        ctl_write(8'h80, 0);
        ctl_write(8'hFF, 0);
        ctl_write(8'h83, 0);
        check("req049_mode_g2", 32'(mode), 2);
        check("req049_color_g2", 32'(color_table_addr), 32'h2000);
        ctl_write(8'h50, 0);
        ctl_write(8'h81, 0);
        check("req049_mode_text", 32'(mode), 0);
        check_outputs();

        // Collision and fifth sprite
        video_event(0, 1, 1, 5'h13);
        status_read(0);
        check("status_bits", 32'(bus.cpu_dout), 32'h73);

        // Reset in the middle of a write, then of a read
        data_write(8'h00, 0, 0);
        strobe(1, 0, 0, 8'h00, 0);
        vram_q.delete();
        m_addr = m_addr - 14'd1;
        ctl_write(8'h10, 0);
        ctl_write(8'h42, 0);
        m_flag = 0;
        vram_q.push_back('{is_wr: 1'b1, a: m_addr, d: 8'hC3});
        mdl_mem[m_addr] = 8'hC3;
        bus.cpu_wr = 1; bus.cpu_mode = 0; bus.cpu_din = 8'hC3;
        tick();
        bus.cpu_wr = 0;
        reset = 1'b1;
        tick();
        check("abort_wr_no_pulse", {bus.vram_wr, bus.vram_rd, bus.cpu_wait}, 0);
        reset = 1'b0;
        model_reset();
        tick();
        check("abort_wr_mem", 32'(vram[14'h0210]), 32'hC3);
        check("abort_cpu_dout", 32'(bus.cpu_dout), 0);
        check_outputs();
        cpu_q.push_back(m_buf);
        vram_q.push_back('{is_wr: 1'b0, a: m_addr, d: 8'h00});
        bus.cpu_rd = 1; bus.cpu_mode = 0;
        tick();
        bus.cpu_rd = 0;
        reset = 1'b1;
        tick();
        check("abort_rd_no_pulse", {bus.vram_wr, bus.vram_rd, bus.cpu_wait}, 0);
        reset = 1'b0;
        model_reset();
        tick();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 6))
                0, 1: ctl_write(8'($urandom), 1'($urandom));
                2:    data_write(8'($urandom), 1'($urandom), $urandom_range(1, 2));
                3, 6: data_read($urandom_range(1, 2));
                4:    status_read(1'($urandom));
                default: video_event(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
            endcase
            check_outputs();
        end

        repeat (4) tick();
        check("vram_q_drained", 32'(vram_q.size()), 0);
        check("cpu_q_drained", 32'(cpu_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
